// File: rtl/dii_packet_arbiter_pkg.sv
// Shared types and constants for the DII packet arbiter.
package dii_arb_pkg;

  localparam int unsigned DII_ARB_CNT_W = 16;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Index width for a port count, never narrower than one bit.
  function automatic int unsigned dii_id_width(input int unsigned ports);
    return (ports > 1) ? 32'($clog2(ports)) : 32'd1;
  endfunction

endpackage

// File: rtl/dii_packet_arbiter_if.sv
// DII multi-port input / single output flit bus bundle.
interface dii_arb_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned PORTS = 4
);

  logic [PORTS-1:0][WIDTH-1:0] in_data;
  logic [PORTS-1:0]            in_first;
  logic [PORTS-1:0]            in_last;
  logic [PORTS-1:0]            in_valid;
  logic [PORTS-1:0]            in_ready;
  logic [WIDTH-1:0]            out_data;
  logic                        out_first;
  logic                        out_last;
  logic                        out_valid;
  logic                        out_ready;

  // Arbiter side.
  modport slave (
    input  in_data, in_first, in_last, in_valid, out_ready,
    output in_ready, out_data, out_first, out_last, out_valid
  );

  // Traffic source/sink side.
  modport master (
    output in_data, in_first, in_last, in_valid, out_ready,
    input  in_ready, out_data, out_first, out_last, out_valid
  );

endinterface

// File: rtl/dii_packet_arbiter_rr_select.sv
// Round-robin search: first requester at or above rr_ptr, wrapping to port 0.
module rr_select
  import dii_arb_pkg::*;
#(
  parameter int unsigned PORTS = 4,
  localparam int unsigned IDW = dii_id_width(PORTS)
) (
  input  logic [PORTS-1:0] i_req,
  input  logic [IDW-1:0]   i_rr_ptr,
  output logic [IDW-1:0]   o_gnt,
  output logic             o_gnt_valid
);

  logic [IDW-1:0] w_hi_idx;
  logic           w_hi_vld;
  logic [IDW-1:0] w_lo_idx;
  logic           w_lo_vld;

  // Downward scan so the lowest qualifying index is the one left standing.
  always_comb begin
    w_hi_idx = '0;
    w_hi_vld = 1'b0;
    w_lo_idx = '0;
    w_lo_vld = 1'b0;
    for (int p = int'(PORTS) - 1; p >= 0; p--) begin
      if (i_req[p]) begin
        w_lo_idx = IDW'(p);
        w_lo_vld = 1'b1;
        if (IDW'(p) >= i_rr_ptr) begin
          w_hi_idx = IDW'(p);
          w_hi_vld = 1'b1;
        end
      end
    end
  end

  assign o_gnt       = w_hi_vld ? w_hi_idx : w_lo_idx;
  assign o_gnt_valid = w_lo_vld;

endmodule

// File: rtl/dii_packet_arbiter.sv
// Packet-locked round-robin arbiter for DII flit channels.
// Optional per-port packet counters: define DII_ARB_STATS_EN.
module dii_packet_arbiter
  import dii_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned PORTS = 4,
  localparam int unsigned IDW = dii_id_width(PORTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dii_arb_if.slave             bus,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy
`ifdef DII_ARB_STATS_EN
  ,
  output logic [PORTS-1:0][DII_ARB_CNT_W-1:0] pkt_count
`endif
);

  arb_state_e     r_state;
  arb_state_e     w_state_nxt;
  logic [IDW-1:0] r_grant;
  logic [IDW-1:0] w_grant_nxt;
  logic [IDW-1:0] r_rr_ptr;
  logic [IDW-1:0] w_rr_ptr_nxt;
  logic [IDW-1:0] w_sel;
  logic           w_sel_vld;
  logic           w_last_xfer;

  rr_select #(.PORTS(PORTS)) u_rr_select (
    .i_req       (bus.in_valid),
    .i_rr_ptr    (r_rr_ptr),
    .o_gnt       (w_sel),
    .o_gnt_valid (w_sel_vld)
  );

  assign w_last_xfer = (r_state == ARB_LOCKED) && bus.in_valid[r_grant] &&
                       bus.out_ready && bus.in_last[r_grant];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ARB_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  // Next state plus the combinational mux from the locked port to the output.
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_rr_ptr_nxt  = r_rr_ptr;
    bus.out_data  = WIDTH'(0);
    bus.out_first = 1'b0;
    bus.out_last  = 1'b0;
    bus.out_valid = 1'b0;
    bus.in_ready  = '0;
    case (r_state)
      ARB_IDLE: begin
        if (w_sel_vld) begin
          w_state_nxt = ARB_LOCKED;
          w_grant_nxt = w_sel;
        end
      end
      ARB_LOCKED: begin
        bus.out_data          = bus.in_data[r_grant];
        bus.out_first         = bus.in_first[r_grant];
        bus.out_last          = bus.in_last[r_grant];
        bus.out_valid         = bus.in_valid[r_grant];
        bus.in_ready[r_grant] = bus.out_ready;
        if (w_last_xfer) begin
          w_state_nxt  = ARB_IDLE;
          w_rr_ptr_nxt = (r_grant == IDW'(PORTS - 1)) ? '0 : r_grant + IDW'(1);
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  assign grant_id = r_grant;
  assign busy     = (r_state == ARB_LOCKED);

`ifdef DII_ARB_STATS_EN
  logic [PORTS-1:0][DII_ARB_CNT_W-1:0] r_pkt_count;

  // Saturating completed-packet counter per port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pkt_count <= '0;
    end else if (w_last_xfer && (r_pkt_count[r_grant] != '1)) begin
      r_pkt_count[r_grant] <= r_pkt_count[r_grant] + DII_ARB_CNT_W'(1);
    end
  end

  assign pkt_count = r_pkt_count;
`endif

endmodule

// File: tb/tb_dii_packet_arbiter.sv
// Directed table-driven bench for dii_packet_arbiter (PORTS=4, WIDTH=16).
module tb_dii_packet_arbiter;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned PORTS = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] grant_id;
  logic       busy;
`ifdef DII_ARB_STATS_EN
  logic [PORTS-1:0][15:0] pkt_count;
`endif

  int total = 0;
  int bad   = 0;

  dii_arb_if #(.WIDTH(WIDTH), .PORTS(PORTS)) bus ();

  dii_packet_arbiter #(.WIDTH(WIDTH), .PORTS(PORTS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy)
`ifdef DII_ARB_STATS_EN
    ,
    .pkt_count(pkt_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  v, f, l;
    logic [15:0] d;
    logic        ordy;
    logic        ovld;
    logic [15:0] odata;
    logic        ofirst, olast;
    logic [3:0]  irdy;
    logic        busy;
    logic [1:0]  gid;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic rst, input logic [3:0] v, f, l,
                              input logic [15:0] d, input logic ordy,
                              input logic ovld, input logic [15:0] odata,
                              input logic ofirst, olast, input logic [3:0] irdy,
                              input logic bsy, input logic [1:0] gid);
    vec_t r;
    r.rst = rst; r.v = v; r.f = f; r.l = l; r.d = d; r.ordy = ordy;
    r.ovld = ovld; r.odata = odata; r.ofirst = ofirst; r.olast = olast;
    r.irdy = irdy; r.busy = bsy; r.gid = gid;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Port p carries d + p*0x1000 so the output identifies its source.
  task automatic drive(input logic [3:0] v, f, l, input logic [15:0] d, input logic ordy);
    for (int p = 0; p < int'(PORTS); p++) bus.in_data[p] = 16'(d + 16'(p * 4096));
    bus.in_valid  = v;
    bus.in_first  = f;
    bus.in_last   = l;
    bus.out_ready = ordy;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(4'b0000, 4'b0000, 4'b0000, 16'h0000, 1'b1);
    #3;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single port 3-flit packet on port 2.
    vq.push_back(mk(1, 4'b0100, 4'b0100, 4'b0000, 16'h0010, 1, 0, 16'h0000, 0, 0, 4'b0000, 0, 0));
    vq.push_back(mk(0, 4'b0100, 4'b0100, 4'b0000, 16'h0010, 1, 1, 16'h2010, 1, 0, 4'b0100, 1, 2));
    vq.push_back(mk(0, 4'b0100, 4'b0000, 4'b0000, 16'h0011, 1, 1, 16'h2011, 0, 0, 4'b0100, 1, 2));
    vq.push_back(mk(0, 4'b0100, 4'b0000, 4'b0100, 16'h0012, 1, 1, 16'h2012, 0, 1, 4'b0100, 1, 2));
    vq.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 16'h0000, 1, 0, 16'h0000, 0, 0, 4'b0000, 0, 0));
    // Contention 0,1,3 then port 0 again.
    vq.push_back(mk(1, 4'b1011, 4'b1011, 4'b1011, 16'h0100, 1, 0, 16'h0000, 0, 0, 4'b0000, 0, 0));
    vq.push_back(mk(0, 4'b1011, 4'b1011, 4'b1011, 16'h0100, 1, 1, 16'h0100, 1, 1, 4'b0001, 1, 0));
    vq.push_back(mk(0, 4'b1010, 4'b1010, 4'b1010, 16'h0100, 1, 0, 16'h0000, 0, 0, 4'b0000, 0, 0));
    vq.push_back(mk(0, 4'b1010, 4'b1010, 4'b1010, 16'h0100, 1, 1, 16'h1100, 1, 1, 4'b0010, 1, 1));
    vq.push_back(mk(0, 4'b1001, 4'b1001, 4'b1001, 16'h0100, 1, 0, 16'h0000, 0, 0, 4'b0000, 0, 0));
    vq.push_back(mk(0, 4'b1001, 4'b1001, 4'b1001, 16'h0100, 1, 1, 16'h3100, 1, 1, 4'b1000, 1, 3));
    vq.push_back(mk(0, 4'b0001, 4'b0001, 4'b0001, 16'h0100, 1, 0, 16'h0000, 0, 0, 4'b0000, 0, 0));
    vq.push_back(mk(0, 4'b0001, 4'b0001, 4'b0001, 16'h0100, 1, 1, 16'h0100, 1, 1, 4'b0001, 1, 0));
    vq.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 16'h0000, 1, 0, 16'h0000, 0, 0, 4'b0000, 0, 0));
    // Wrap: port 2 first sets rr_ptr=3, then ports 0 and 3.
    vq.push_back(mk(1, 4'b0100, 4'b0100, 4'b0100, 16'h0200, 1, 0, 16'h0000, 0, 0, 4'b0000, 0, 0));
    vq.push_back(mk(0, 4'b0100, 4'b0100, 4'b0100, 16'h0200, 1, 1, 16'h2200, 1, 1, 4'b0100, 1, 2));
    vq.push_back(mk(0, 4'b1001, 4'b1001, 4'b1001, 16'h0200, 1, 0, 16'h0000, 0, 0, 4'b0000, 0, 0));
    vq.push_back(mk(0, 4'b1001, 4'b1001, 4'b1001, 16'h0200, 1, 1, 16'h3200, 1, 1, 4'b1000, 1, 3));
    vq.push_back(mk(0, 4'b0001, 4'b0001, 4'b0001, 16'h0200, 1, 0, 16'h0000, 0, 0, 4'b0000, 0, 0));
    vq.push_back(mk(0, 4'b0001, 4'b0001, 4'b0001, 16'h0200, 1, 1, 16'h0200, 1, 1, 4'b0001, 1, 0));
    vq.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 16'h0000, 1, 0, 16'h0000, 0, 0, 4'b0000, 0, 0));
    // Backpressure 1,0,0,1 on a 4-flit port-1 packet, port 0 competing, valid gap.
    vq.push_back(mk(1, 4'b0010, 4'b0010, 4'b0000, 16'h0300, 1, 0, 16'h0000, 0, 0, 4'b0000, 0, 0));
    vq.push_back(mk(0, 4'b0010, 4'b0010, 4'b0000, 16'h0300, 1, 1, 16'h1300, 1, 0, 4'b0010, 1, 1));
    vq.push_back(mk(0, 4'b0011, 4'b0001, 4'b0001, 16'h0301, 0, 1, 16'h1301, 0, 0, 4'b0000, 1, 1));
    vq.push_back(mk(0, 4'b0011, 4'b0001, 4'b0001, 16'h0301, 0, 1, 16'h1301, 0, 0, 4'b0000, 1, 1));
    vq.push_back(mk(0, 4'b0011, 4'b0001, 4'b0001, 16'h0301, 1, 1, 16'h1301, 0, 0, 4'b0010, 1, 1));
    vq.push_back(mk(0, 4'b0001, 4'b0001, 4'b0001, 16'h0301, 1, 0, 16'h0000, 0, 0, 4'b0010, 1, 1));
    vq.push_back(mk(0, 4'b0011, 4'b0001, 4'b0001, 16'h0302, 1, 1, 16'h1302, 0, 0, 4'b0010, 1, 1));
    vq.push_back(mk(0, 4'b0011, 4'b0001, 4'b0011, 16'h0303, 1, 1, 16'h1303, 0, 1, 4'b0010, 1, 1));
    vq.push_back(mk(0, 4'b0001, 4'b0001, 4'b0001, 16'h0303, 1, 0, 16'h0000, 0, 0, 4'b0000, 0, 0));
    vq.push_back(mk(0, 4'b0001, 4'b0001, 4'b0001, 16'h0303, 1, 1, 16'h0303, 1, 1, 4'b0001, 1, 0));
    vq.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 16'h0000, 1, 0, 16'h0000, 0, 0, 4'b0000, 0, 0));

    foreach (vq[i]) begin
      if (vq[i].rst) do_reset();
      @(posedge clk);
      #1;
      drive(vq[i].v, vq[i].f, vq[i].l, vq[i].d, vq[i].ordy);
      @(negedge clk);
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vq[i].busy));
      chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(vq[i].ovld));
      chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'(vq[i].irdy));
      if (vq[i].ovld) begin
        chk($sformatf("v%0d_out_data", i), 32'(bus.out_data), 32'(vq[i].odata));
        chk($sformatf("v%0d_out_first", i), 32'(bus.out_first), 32'(vq[i].ofirst));
        chk($sformatf("v%0d_out_last", i), 32'(bus.out_last), 32'(vq[i].olast));
      end
      if (vq[i].busy) chk($sformatf("v%0d_grant_id", i), 32'(grant_id), 32'(vq[i].gid));
    end

    // Reset mid-packet: rr_ptr is 1 here, so a clean restart must pick port 0 over 2.
    @(posedge clk); #1; drive(4'b1000, 4'b1000, 4'b0000, 16'h0400, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_lock3", 32'(grant_id), 32'd3);
    @(posedge clk); #1; drive(4'b1000, 4'b0000, 4'b0000, 16'h0401, 1'b1);
    @(negedge clk);
    chk("mid_flit1_data", 32'(bus.out_data), 32'h3401);
    @(posedge clk); #1; drive(4'b1101, 4'b0101, 4'b0101, 16'h0402, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("mid_rst_grant_id", 32'(grant_id), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b0101, 4'b0101, 4'b0101, 16'h0402, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd1);
    chk("post_rst_grant", 32'(grant_id), 32'd0);
    chk("post_rst_data", 32'(bus.out_data), 32'h0402);
    @(posedge clk); #1; drive(4'b0000, 4'b0000, 4'b0000, 16'h0000, 1'b1);

`ifdef DII_ARB_STATS_EN
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1; drive(4'b0010, 4'b0010, 4'b0010, 16'(k), 1'b1);
      @(posedge clk); #1;
      @(posedge clk); #1; drive(4'b0000, 4'b0000, 4'b0000, 16'h0000, 1'b1);
    end
    @(negedge clk);
    chk("stats_p1", 32'(pkt_count[1]), 32'd5);
    chk("stats_p0", 32'(pkt_count[0]), 32'd0);
    chk("stats_p2", 32'(pkt_count[2]), 32'd0);
    chk("stats_p3", 32'(pkt_count[3]), 32'd0);
    force dut.r_pkt_count = {16'h0000, 16'h0000, 16'hFFFF, 16'h0000};
    @(negedge clk);
    release dut.r_pkt_count;
    @(posedge clk); #1; drive(4'b0010, 4'b0010, 4'b0010, 16'h0009, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1; drive(4'b0000, 4'b0000, 4'b0000, 16'h0000, 1'b1);
    @(negedge clk);
    chk("stats_sat", 32'(pkt_count[1]), 32'h0000FFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dii_packet_arbiter.md
DII_PACKET_ARBITER -- requirements
Module: dii_packet_arbiter

Interface
REQ-001 Parameter: WIDTH, 16, DII flit data width.
REQ-002 Parameter: PORTS, 4, number of requesting DII input channels (1..16).
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: in_data  input  PORTS x WIDTH  flit data per input port.
REQ-006 Port: in_first / in_last / in_valid  input  PORTS each  per-port flit markers and valid.
REQ-007 Port: in_ready  output  PORTS  per-port ready.
REQ-008 Port: out_data  output  WIDTH; out_first, out_last, out_valid  output  1 each; out_ready  input  1.
REQ-009 Port: grant_id  output  $clog2(PORTS) (min 1)  index of the locked port; busy  output  1  a packet is locked.

Function
REQ-010 The block SHALL have two states: IDLE (no port locked) and LOCKED (one port owns the output until its last flit transfers).
REQ-011 In IDLE, out_valid and all in_ready SHALL be 0.
REQ-012 In IDLE with any in_valid high, the block SHALL select the first requesting port, searching upward from rr_ptr with wrap-around from PORTS-1 to 0, and enter LOCKED next cycle with grant_id = that port.
REQ-013 In LOCKED, out_data/out_first/out_last/out_valid SHALL equal the granted port's inputs combinationally, in_ready[grant_id] SHALL equal out_ready, and all other in_ready SHALL be 0.
REQ-014 A transfer SHALL occur when out_valid && out_ready; a transfer with out_last=1 SHALL return the block to IDLE next cycle and set rr_ptr = (grant_id+1) mod PORTS.
REQ-015 Minimum latency from in_valid rising in IDLE to out_valid SHALL be 1 cycle; one IDLE bubble cycle SHALL separate consecutive packets.
REQ-016 The block SHALL NOT re-arbitrate mid-packet: in LOCKED, in_valid[grant_id] dropping low, or other ports requesting, SHALL leave the grant unchanged.
REQ-017 A single-flit packet (first=1, last=1) SHALL lock for exactly one transfer.
REQ-018 in_first is forwarded only; its value SHALL NOT affect state.
REQ-019 out_ready low SHALL hold all state; no flit may be dropped or duplicated.
REQ-020 With PORTS=1, the block SHALL behave identically with grant_id fixed at 0.

Reset
REQ-021 Asserting rst_n low SHALL immediately (asynchronously) force IDLE, rr_ptr=0, grant_id=0, busy=0, out_valid=0, in_ready=0.
REQ-022 Reset asserted mid-packet SHALL abandon the packet; after release, arbitration SHALL restart from port 0.

Configuration
REQ-023 Macro DII_ARB_STATS_EN: when defined, the block SHALL add output pkt_count (PORTS x 16) holding per-port completed-packet counts, incremented on each last-flit transfer, saturating at 16'hFFFF, reset to 0.
REQ-024 Without DII_ARB_STATS_EN, the pkt_count port and counters SHALL be absent; all other behaviour is unchanged.

Structure
REQ-025 A shared package dii_arb_pkg SHALL hold the state enum (ARB_IDLE, ARB_LOCKED) and the counter width constant DII_ARB_CNT_W=16.
REQ-026 The round-robin search SHALL live in a sub-module rr_select (inputs: req vector, rr_ptr; outputs: gnt index, gnt_valid).

Verification
REQ-027 Single port: port 2 sends a 3-flit packet (first on flit 0, last on flit 2), out_ready=1 -> out_valid from cycle 1, 3 transfers, grant_id=2, IDLE at cycle 4.
REQ-028 Contention: ports 0,1,3 all valid after reset -> packets granted in order 0,1,3, then port 0 again if it re-requests.
REQ-029 Wrap: rr_ptr=3 with ports 0 and 3 requesting -> port 3 granted first, then port 0.
REQ-030 Backpressure: out_ready toggles 1,0,0,1 during a 4-flit packet -> no loss or duplication; in_ready[grant_id] mirrors out_ready.
REQ-031 Reset mid-packet: rst_n low after flit 1 of 4 -> out_valid=0 and busy=0 immediately; next grant goes to the lowest requesting port.
REQ-032 Stats (DII_ARB_STATS_EN): 5 packets on port 1 -> pkt_count[1]=5, others 0; forcing the counter to 16'hFFFF and sending one more packet -> stays 16'hFFFF.
